// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State encoding and IR field positions.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam int INSTR_W = 8;

    localparam int IR1_MSB = 7;
    localparam int IR1_LSB = 4;
    localparam int IR2_MSB = 3;
    localparam int IR2_LSB = 2;
    localparam int IR3_MSB = 1;
    localparam int IR3_LSB = 0;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack for call/return.
// Full/empty come from a pointer one bit wider than the index.
module ret_stack #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(D);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [D];
    logic [PW-1:0] ptr;
    logic [AW-1:0] top_idx;

    assign full    = (ptr == PW'(D));
    assign empty   = (ptr == '0);
    assign top_idx = ptr[AW-1:0] - AW'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            for (int i = 0; i < D; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[ptr[AW-1:0]] <= din;
            ptr              <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencing: PC, IR, req/ack fetch FSM,
// ack timeout retry and next-PC selection with call/return.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              STACK_D  = 4,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [3:0]      ir_1,
    output logic [1:0]      ir_2,
    output logic [1:0]      ir_3,
    output logic            ir_valid,
    input  logic            branch,
    input  logic            muxpush,
    input  logic            muxreturn,
    input  logic            intisCond,
    input  logic            cond_flag,
    input  logic [PC_W-1:0] target,
    input  logic            stall,
    output logic [PC_W-1:0] pc,
    output logic            stack_err,
    output logic            fetch_err
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [PC_W-1:0]    pc_nxt;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    stk_top;
    logic               stk_full;
    logic               stk_empty;
    logic               stk_push;
    logic               stk_pop;
    logic               err_set;
    logic               timeout;
    logic               issue_go;
    logic               taken;

    assign pc_inc    = pc + PC_W'(1);
    assign imem_addr = pc;
    assign ir_1      = ir_q[IR1_MSB:IR1_LSB];
    assign ir_2      = ir_q[IR2_MSB:IR2_LSB];
    assign ir_3      = ir_q[IR3_MSB:IR3_LSB];

    assign timeout  = (state == REQ) && !imem_ack && (wait_cnt == LIMIT);
    assign issue_go = (state == ISSUE) && !stall;
    assign taken    = branch && (!intisCond || cond_flag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = REQ;
            REQ: begin
                if (imem_ack) begin
                    state_nxt = ISSUE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt   = pc;
        ir_nxt   = ir_q;
        cnt_nxt  = '0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        err_set  = 1'b0;
        if (state == REQ) begin
            if (imem_ack) begin
                ir_nxt = imem_data;
            end else if (!timeout) begin
                cnt_nxt = wait_cnt + CNT_W'(1);
            end
        end
        // Return beats branch; a failed return still advances.
        if (issue_go) begin
            if (muxreturn) begin
                if (stk_empty) begin
                    pc_nxt  = pc_inc;
                    err_set = 1'b1;
                end else begin
                    pc_nxt  = stk_top;
                    stk_pop = 1'b1;
                end
            end else if (taken) begin
                pc_nxt = target;
                if (muxpush) begin
                    stk_push = !stk_full;
                    err_set  = stk_full;
                end
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            ir_q      <= '0;
            wait_cnt  <= '0;
            imem_req  <= 1'b0;
            ir_valid  <= 1'b0;
            stack_err <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            ir_q      <= ir_nxt;
            wait_cnt  <= cnt_nxt;
            imem_req  <= (state_nxt == REQ);
            ir_valid  <= (state_nxt == ISSUE);
            stack_err <= stack_err | err_set;
            fetch_err <= timeout;
        end
    end

    ret_stack #(
        .W (PC_W),
        .D (STACK_D)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory/controller driver
// pushes expectations, a negedge monitor pops and compares.
module tb_instr_fetch_unit;

    typedef struct {
        logic [7:0] addr;
        logic       err;
        logic [7:0] data;
        logic       br;
        logic       push;
        logic       ret;
        logic       cen;
        logic       cflag;
        logic [7:0] tgt;
        int         nstall;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = '0;
    logic [3:0] ir_1;
    logic [1:0] ir_2;
    logic [1:0] ir_3;
    logic       ir_valid;
    logic       branch = 1'b0;
    logic       muxpush = 1'b0;
    logic       muxreturn = 1'b0;
    logic       intisCond = 1'b0;
    logic       cond_flag = 1'b0;
    logic [7:0] target = '0;
    logic       stall = 1'b0;
    logic [7:0] pc;
    logic       stack_err;
    logic       fetch_err;

    int n_checks = 0;
    int n_fail = 0;
    int ferr_pulses = 0;

    logic [8:0] addr_q[$];
    logic [7:0] ir_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .PC_W     (8),
        .RESET_PC (8'h00),
        .STACK_D  (4),
        .TIMEOUT  (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir_1      (ir_1),
        .ir_2      (ir_2),
        .ir_3      (ir_3),
        .ir_valid  (ir_valid),
        .branch    (branch),
        .muxpush   (muxpush),
        .muxreturn (muxreturn),
        .intisCond (intisCond),
        .cond_flag (cond_flag),
        .target    (target),
        .stall     (stall),
        .pc        (pc),
        .stack_err (stack_err),
        .fetch_err (fetch_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (fetch_err) ferr_pulses++;
            if (imem_req && imem_ack) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_fetch", 32'(imem_addr), 32'hffff);
                end else begin
                    logic [8:0] e;
                    e = addr_q.pop_front();
                    chk("fetch_addr", 32'(imem_addr), 32'(e[7:0]));
                    chk("pc", 32'(pc), 32'(e[7:0]));
                    chk("stack_err", 32'(stack_err), 32'(e[8]));
                end
            end
            if (ir_valid) begin
                if (ir_q.size() == 0) begin
                    chk("unexpected_ir_valid", 32'(ir_valid), 32'h0);
                end else begin
                    chk("ir_fields", 32'({ir_1, ir_2, ir_3}), 32'(ir_q[0]));
                    if (!stall) void'(ir_q.pop_front());
                end
            end
        end
    end

    function automatic vec_t mk(input logic [7:0] a, input logic e,
                                input logic [7:0] d, input logic b,
                                input logic p, input logic r,
                                input logic c, input logic f,
                                input logic [7:0] t, input int s);
        vec_t v;
        v.addr = a; v.err = e; v.data = d; v.br = b; v.push = p;
        v.ret = r; v.cen = c; v.cflag = f; v.tgt = t; v.nstall = s;
        return v;
    endfunction

    task automatic do_fetch(input vec_t v);
        int n;
        n = 0;
        while (!imem_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'h1);
        if (imem_req) begin
            addr_q.push_back({v.err, v.addr});
            ir_q.push_back(v.data);
            imem_ack  = 1'b1;
            imem_data = v.data;
            branch    = v.br;
            muxpush   = v.push;
            muxreturn = v.ret;
            intisCond = v.cen;
            cond_flag = v.cflag;
            target    = v.tgt;
            stall     = (v.nstall > 0);
            @(posedge clk); #1;
            imem_ack  = 1'b0;
            imem_data = '0;
            for (int i = 0; i < v.nstall; i++) begin
                @(posedge clk); #1;
            end
            stall = 1'b0;
            @(posedge clk); #1;
            branch = 0; muxpush = 0; muxreturn = 0;
            intisCond = 0; cond_flag = 0; target = '0;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_pc"}, 32'(pc), 32'h0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
        chk({tag, "_ir"}, 32'({ir_1, ir_2, ir_3}), 32'h0);
        chk({tag, "_valid"}, 32'(ir_valid), 32'h0);
        chk({tag, "_serr"}, 32'(stack_err), 32'h0);
        chk({tag, "_ferr"}, 32'(fetch_err), 32'h0);
    endtask

    vec_t va[$];
    vec_t vb[$];
    vec_t vc[$];

    initial begin
        //         addr  err data   br p  r  c  f  tgt    stall
        va.push_back(mk(8'h00, 0, 8'hFB, 1, 0, 0, 1, 0, 8'h40, 0));
        va.push_back(mk(8'h01, 0, 8'h12, 1, 0, 0, 1, 1, 8'h40, 0));
        va.push_back(mk(8'h40, 0, 8'h3C, 1, 0, 0, 0, 0, 8'h05, 0));
        va.push_back(mk(8'h05, 0, 8'hA5, 1, 1, 0, 0, 0, 8'h20, 0));
        va.push_back(mk(8'h20, 0, 8'h5A, 0, 0, 0, 0, 0, 8'h00, 0));
        va.push_back(mk(8'h21, 0, 8'h81, 0, 0, 1, 0, 0, 8'h00, 0));
        va.push_back(mk(8'h06, 0, 8'h7E, 0, 0, 1, 0, 0, 8'h00, 0));
        va.push_back(mk(8'h07, 1, 8'hC3, 0, 1, 0, 0, 0, 8'h60, 0));
        va.push_back(mk(8'h08, 1, 8'h24, 0, 0, 1, 0, 0, 8'h00, 0));
        vb.push_back(mk(8'h00, 0, 8'h11, 1, 1, 0, 0, 0, 8'h10, 0));
        vb.push_back(mk(8'h10, 0, 8'h22, 1, 1, 0, 0, 0, 8'h20, 0));
        vb.push_back(mk(8'h20, 0, 8'h33, 1, 1, 0, 0, 0, 8'h30, 0));
        vb.push_back(mk(8'h30, 0, 8'h44, 1, 1, 0, 0, 0, 8'h40, 0));
        vb.push_back(mk(8'h40, 0, 8'h55, 1, 1, 0, 0, 0, 8'h50, 0));
        vb.push_back(mk(8'h50, 1, 8'h66, 0, 0, 1, 0, 0, 8'h00, 0));
        vb.push_back(mk(8'h31, 1, 8'h77, 0, 0, 1, 0, 0, 8'h00, 0));
        vb.push_back(mk(8'h21, 1, 8'h88, 0, 0, 1, 0, 0, 8'h00, 0));
        vb.push_back(mk(8'h11, 1, 8'h99, 0, 0, 1, 0, 0, 8'h00, 0));
        vb.push_back(mk(8'h01, 1, 8'hAA, 1, 0, 0, 0, 0, 8'hFF, 0));
        vb.push_back(mk(8'hFF, 1, 8'hBB, 0, 0, 0, 0, 0, 8'h00, 0));
        vb.push_back(mk(8'h00, 1, 8'hCC, 0, 0, 0, 0, 0, 8'h00, 2));
        vc.push_back(mk(8'h01, 1, 8'hDD, 0, 0, 0, 0, 0, 8'h00, 0));
        vc.push_back(mk(8'h02, 1, 8'hEE, 0, 0, 0, 0, 0, 8'h00, 0));

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("por");
        #2 reset = 1'b1;
        @(posedge clk); #1;

        foreach (va[i]) do_fetch(va[i]);

        // Abandon the pending fetch at 09 with an async reset.
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        chk("pre_rst_addr", 32'(imem_addr), 32'h09);
        #2 reset = 1'b0;
        #1;
        chk_reset_state("mid");
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vb[i]) do_fetch(vb[i]);

        begin
            int n;
            n = 0;
            while (imem_req && n < 40) begin
                n++;
                @(posedge clk); #1;
            end
            chk("req_cycles_before_timeout", 32'(n), 32'd15);
            chk("fetch_err_pulse", 32'(fetch_err), 32'h1);
            chk("req_dropped", 32'(imem_req), 32'h0);
            @(posedge clk); #1;
            chk("retry_req", 32'(imem_req), 32'h1);
            chk("retry_addr", 32'(imem_addr), 32'h01);
            chk("fetch_err_clear", 32'(fetch_err), 32'h0);
        end

        foreach (vc[i]) do_fetch(vc[i]);

        repeat (2) @(posedge clk);
        #1;
        chk("addr_q_drained", 32'(addr_q.size()), 32'h0);
        chk("ir_q_drained", 32'(ir_q.size()), 32'h0);
        chk("fetch_err_count", 32'(ferr_pulses), 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
